axi_req_scheduler: RTL and testbench
====================================

Name: axi_req_scheduler

Overview:
- Parametrised successor to the fixed 4-write/1-read FIFO request logic between the video line FIFOs and the simplified AXI master.
- Watches NUM_WR_CH input-FIFO read-side water levels and one output-FIFO write-side level.
- Issues one burst command at a time over a valid/ready/done handshake, using round-robin write arbitration and read gating.
- Also generates stretched per-FIFO reset pulses and the post-reset read holdoff.

Parameters:
NUM_WR_CH, 4, number of write (video input) channels, 1..16
LEVEL_W, 10, width of each water-level input
WR_THRESH, 120, write-eligible when channel level >= this (one line of bursts)
RD_THRESH, 239, read-eligible when output level < this
RD_CRIT, 32, output level below which read is urgent (optional feature)
HOLDOFF_CYC, 1000, cycles after output-FIFO reset before any read is issued
RST_STRETCH, 16, length in cycles of generated FIFO reset pulses
CH_W, $clog2(NUM_WR_CH) (min 1), width of channel index

Ports:
ddrphy_clkin  in  1  single clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_level  in  NUM_WR_CH*LEVEL_W  packed input-FIFO levels, channel i at [i*LEVEL_W +: LEVEL_W]
rd_level  in  LEVEL_W  output-FIFO write-side level
ch_rst_in  in  NUM_WR_CH  per-channel reset requests, already synchronous to ddrphy_clkin
o_rst_in  in  1  output-FIFO reset request, synchronous
ch_fifo_rst  out  NUM_WR_CH  stretched reset to each input FIFO
o_fifo_rst  out  1  stretched reset to the output FIFO
cmd_valid  out  1  burst command valid
cmd_ready  in  1  AXI master accepts the command
cmd_is_rd  out  1  1 = read burst, 0 = write burst
cmd_ch  out  CH_W  write channel index; 0 when cmd_is_rd = 1
cmd_done  in  1  single-cycle pulse when the accepted burst completes
busy  out  1  high from command issue until cmd_done

Behaviour:
- Reset (rst = 1 on a clock edge):
  - All outputs go to 0, FSM enters IDLE and the round-robin pointer goes to 0.
  - The holdoff counter goes to 0, so reads are blocked for HOLDOFF_CYC cycles after reset.
  - Edge-detect registers and stretch counters clear.
- Reset stretch:
  - A rising edge on ch_rst_in[i] (registered previous value 0, current 1) drives ch_fifo_rst[i] high starting the next cycle for exactly RST_STRETCH cycles.
  - A new rising edge during a stretch restarts the count.
  - Channels are independent.
- Output reset and holdoff:
  - A rising edge on o_rst_in clears the holdoff counter in the next cycle.
  - o_fifo_rst rises one cycle after that and stays high for RST_STRETCH cycles, so the counter is cleared before the FIFO resets.
  - The counter increments each cycle and saturates at HOLDOFF_CYC.
  - holdoff_ok = (counter == HOLDOFF_CYC) and o_fifo_rst == 0.
- Eligibility (combinational, evaluated in IDLE):
  - wr_elig[i] = wr_level_i >= WR_THRESH and ch_fifo_rst[i] == 0.
  - rd_elig = rd_level < RD_THRESH and holdoff_ok.
- FSM states are IDLE, ISSUE and WAIT_DONE.
- IDLE:
  - If any request is eligible, select a winner, register cmd_is_rd and cmd_ch, assert cmd_valid and go to ISSUE.
  - Otherwise stay. IDLE always lasts at least 1 cycle after cmd_done, so FIFO levels are re-sampled.
- Selection:
  - Writes have priority over reads.
  - The write winner is the first eligible channel searching upward from the pointer, wrapping NUM_WR_CH-1 -> 0.
  - A read is chosen only when no write is eligible.
- ISSUE:
  - cmd_valid, cmd_is_rd and cmd_ch are held stable until cmd_ready is sampled high, even if eligibility changes or a channel reset occurs.
  - On the handshake: cmd_valid goes to 0 and busy to 1. If it was a write, pointer = (winner + 1) mod NUM_WR_CH.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - On cmd_done: busy goes to 0 and the FSM returns to IDLE.
  - cmd_done outside WAIT_DONE is ignored.
  - There is no abort; a channel reset here does not change state.
- Latency: at most 1 cycle from an eligible request in IDLE to cmd_valid high. Minimum cycle per burst is IDLE, ISSUE, WAIT_DONE = 3 cycles.
- Simultaneous events: rst overrides everything. A ch_rst_in edge in the same cycle as an IDLE decision does not affect that decision, because ch_fifo_rst rises one cycle later.

Optional Feature:
- Macro: READ_PRIO_EN.
- Defined: if rd_elig and rd_level < RD_CRIT, the read wins over any eligible writes, and the pointer is unchanged.
- Undefined: strict write-first selection as described above; RD_CRIT is unused.

Test Plan:
- Set all levels below WR_THRESH and rd_level = 0, run 1000 cycles after rst: no cmd_valid before cycle 1000, then a read command with cmd_is_rd = 1 and cmd_ch = 0.
- Hold all 4 wr_level = 120 and complete each burst with cmd_ready = 1 and cmd_done 2 cycles later: grants go in order 0, 1, 2, 3, 0.
- Only channel 2 eligible and cmd_ready held low for 10 cycles while channel 2's level drops to 0: cmd_valid stays 1 with cmd_ch = 2 throughout, then busy rises after ready.
- Pulse ch_rst_in[1] for 1 cycle: ch_fifo_rst[1] high for exactly 16 cycles starting 1 cycle later, and channel 1 is not granted during that window even at level 200.
- Pulse o_rst_in mid-operation: o_fifo_rst is high for 16 cycles starting 2 cycles later, and no read is issued for 1000 cycles after the counter clears.
- With READ_PRIO_EN defined, rd_level = 10 and channel 0 eligible: a read is granted first. Without the macro, channel 0 is granted first.

Source files
------------

// File: rtl/axi_req_scheduler.sv
// Burst command scheduler: round-robin write arbitration, gated reads, stretched FIFO resets
// and post-reset read holdoff. Optional read-urgency override: define READ_PRIO_EN.
module axi_req_scheduler #(
  parameter int unsigned NUM_WR_CH   = 4,
  parameter int unsigned LEVEL_W     = 10,
  parameter int unsigned WR_THRESH   = 120,
  parameter int unsigned RD_THRESH   = 239,
  parameter int unsigned RD_CRIT     = 32,
  parameter int unsigned HOLDOFF_CYC = 1000,
  parameter int unsigned RST_STRETCH = 16,
  parameter int unsigned CH_W        = (NUM_WR_CH > 1) ? $clog2(NUM_WR_CH) : 1
) (
  input  logic                         ddrphy_clkin,
  input  logic                         rst,
  input  logic [NUM_WR_CH*LEVEL_W-1:0] wr_level,
  input  logic [LEVEL_W-1:0]           rd_level,
  input  logic [NUM_WR_CH-1:0]         ch_rst_in,
  input  logic                         o_rst_in,
  output logic [NUM_WR_CH-1:0]         ch_fifo_rst,
  output logic                         o_fifo_rst,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic                         cmd_is_rd,
  output logic [CH_W-1:0]              cmd_ch,
  input  logic                         cmd_done,
  output logic                         busy
);

  localparam int unsigned STR_W  = $clog2(RST_STRETCH + 1);
  localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYC + 1);

  localparam logic [STR_W-1:0]   LP_STRETCH   = STR_W'(RST_STRETCH);
  localparam logic [HOLD_W-1:0]  LP_HOLDOFF   = HOLD_W'(HOLDOFF_CYC);
  localparam logic [LEVEL_W-1:0] LP_WR_THRESH = LEVEL_W'(WR_THRESH);
  localparam logic [LEVEL_W-1:0] LP_RD_THRESH = LEVEL_W'(RD_THRESH);
  localparam logic [LEVEL_W-1:0] LP_RD_CRIT   = LEVEL_W'(RD_CRIT);

`ifdef READ_PRIO_EN
  localparam logic LP_RD_PRIO = 1'b1;
`else
  localparam logic LP_RD_PRIO = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [NUM_WR_CH-1:0] r_ch_rst_prev;
  logic [STR_W-1:0]     r_ch_cnt [NUM_WR_CH];
  logic [NUM_WR_CH-1:0] w_ch_edge;

  logic                 r_o_rst_prev;
  logic                 r_o_pend;
  logic [STR_W-1:0]     r_o_cnt;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic                 w_o_edge;
  logic                 w_o_fifo_rst;
  logic                 w_hold_ok;

  logic [NUM_WR_CH-1:0] w_wr_elig;
  logic                 w_wr_found;
  logic [CH_W-1:0]      w_wr_win;
  logic                 w_rd_elig;
  logic                 w_rd_pri;

  logic [CH_W-1:0]      r_ptr;
  logic [CH_W-1:0]      w_ptr_nxt;
  logic [CH_W-1:0]      w_ptr_inc;
  logic [31:0]          w_ch_inc;

  logic                 r_cmd_valid;
  logic                 w_cmd_valid_nxt;
  logic                 r_cmd_is_rd;
  logic                 w_cmd_is_rd_nxt;
  logic [CH_W-1:0]      r_cmd_ch;
  logic [CH_W-1:0]      w_cmd_ch_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;

  // Per-channel reset stretch; a fresh rising edge reloads the counter.
  assign w_ch_edge = ch_rst_in & ~r_ch_rst_prev;

  always_ff @(posedge ddrphy_clkin) begin
    if (rst) begin
      r_ch_rst_prev <= '0;
      for (int unsigned i = 0; i < NUM_WR_CH; i++) begin
        r_ch_cnt[i] <= '0;
      end
    end else begin
      r_ch_rst_prev <= ch_rst_in;
      for (int unsigned i = 0; i < NUM_WR_CH; i++) begin
        if (w_ch_edge[i]) begin
          r_ch_cnt[i] <= LP_STRETCH;
        end else if (r_ch_cnt[i] != '0) begin
          r_ch_cnt[i] <= r_ch_cnt[i] - STR_W'(1);
        end
      end
    end
  end

  always_comb begin
    ch_fifo_rst = '0;
    for (int unsigned i = 0; i < NUM_WR_CH; i++) begin
      ch_fifo_rst[i] = (r_ch_cnt[i] != '0);
    end
  end

  // Holdoff counter clears on the request edge; the FIFO reset is delayed one cycle behind it.
  assign w_o_edge     = o_rst_in & ~r_o_rst_prev;
  assign w_o_fifo_rst = (r_o_cnt != '0);
  assign w_hold_ok    = (r_hold_cnt == LP_HOLDOFF) && !w_o_fifo_rst;

  always_ff @(posedge ddrphy_clkin) begin
    if (rst) begin
      r_o_rst_prev <= 1'b0;
      r_o_pend     <= 1'b0;
      r_o_cnt      <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_o_rst_prev <= o_rst_in;
      r_o_pend     <= w_o_edge;
      if (r_o_pend) begin
        r_o_cnt <= LP_STRETCH;
      end else if (r_o_cnt != '0) begin
        r_o_cnt <= r_o_cnt - STR_W'(1);
      end
      if (w_o_edge) begin
        r_hold_cnt <= '0;
      end else if (r_hold_cnt != LP_HOLDOFF) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
    end
  end

  always_comb begin
    w_wr_elig = '0;
    for (int unsigned i = 0; i < NUM_WR_CH; i++) begin
      w_wr_elig[i] = (wr_level[i*LEVEL_W +: LEVEL_W] >= LP_WR_THRESH) && !ch_fifo_rst[i];
    end
  end

  assign w_rd_elig = (rd_level < LP_RD_THRESH) && w_hold_ok;
  assign w_rd_pri  = LP_RD_PRIO && w_rd_elig && (rd_level < LP_RD_CRIT);

  // Round-robin search upward from the pointer, wrapping at NUM_WR_CH.
  always_comb begin : p_rr
    int unsigned v_idx;
    v_idx      = 0;
    w_wr_found = 1'b0;
    w_wr_win   = '0;
    for (int unsigned k = 0; k < NUM_WR_CH; k++) begin
      v_idx = k + 32'(r_ptr);
      if (v_idx >= NUM_WR_CH) begin
        v_idx = v_idx - NUM_WR_CH;
      end
      if (!w_wr_found && w_wr_elig[v_idx]) begin
        w_wr_found = 1'b1;
        w_wr_win   = CH_W'(v_idx);
      end
    end
  end

  always_comb begin
    w_ch_inc  = 32'(r_cmd_ch) + 32'd1;
    w_ptr_inc = (w_ch_inc >= NUM_WR_CH) ? '0 : CH_W'(w_ch_inc);
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_valid_nxt = r_cmd_valid;
    w_cmd_is_rd_nxt = r_cmd_is_rd;
    w_cmd_ch_nxt    = r_cmd_ch;
    w_busy_nxt      = r_busy;
    w_ptr_nxt       = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_rd_pri || (!w_wr_found && w_rd_elig)) begin
          w_cmd_valid_nxt = 1'b1;
          w_cmd_is_rd_nxt = 1'b1;
          w_cmd_ch_nxt    = '0;
          w_state_nxt     = S_ISSUE;
        end else if (w_wr_found) begin
          w_cmd_valid_nxt = 1'b1;
          w_cmd_is_rd_nxt = 1'b0;
          w_cmd_ch_nxt    = w_wr_win;
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          w_cmd_valid_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
          if (!r_cmd_is_rd) begin
            w_ptr_nxt = w_ptr_inc;
          end
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (cmd_done) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ddrphy_clkin) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_is_rd <= 1'b0;
      r_cmd_ch    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cmd_is_rd <= w_cmd_is_rd_nxt;
      r_cmd_ch    <= w_cmd_ch_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign o_fifo_rst = w_o_fifo_rst;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_is_rd  = r_cmd_is_rd;
  assign cmd_ch     = r_cmd_ch;
  assign busy       = r_busy;

endmodule

// File: tb/tb_axi_req_scheduler.sv
// Self-checking bench for axi_req_scheduler: directed scenarios plus a randomized phase,
// all outputs compared every cycle against a time-stamp based reference model.
`timescale 1ns/1ps
module tb_axi_req_scheduler;

  localparam int N     = 4;
  localparam int LW    = 10;
  localparam int WR_TH = 120;
  localparam int RD_TH = 239;
  localparam int RD_CR = 32;
  localparam int HOLD  = 1000;
  localparam int STR   = 16;
  localparam int CHW   = 2;
  localparam int NEVER = -1000000;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*LW-1:0] wr_level;
  logic [LW-1:0]   rd_level;
  logic [N-1:0]    ch_rst_in;
  logic            o_rst_in;
  logic [N-1:0]    ch_fifo_rst;
  logic            o_fifo_rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_is_rd;
  logic [CHW-1:0]  cmd_ch;
  logic            cmd_done;
  logic            busy;

  always #5 clk = ~clk;

  axi_req_scheduler #(
    .NUM_WR_CH  (N),
    .LEVEL_W    (LW),
    .WR_THRESH  (WR_TH),
    .RD_THRESH  (RD_TH),
    .RD_CRIT    (RD_CR),
    .HOLDOFF_CYC(HOLD),
    .RST_STRETCH(STR)
  ) dut (
    .ddrphy_clkin(clk),
    .rst         (rst),
    .wr_level    (wr_level),
    .rd_level    (rd_level),
    .ch_rst_in   (ch_rst_in),
    .o_rst_in    (o_rst_in),
    .ch_fifo_rst (ch_fifo_rst),
    .o_fifo_rst  (o_fifo_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_is_rd   (cmd_is_rd),
    .cmd_ch      (cmd_ch),
    .cmd_done    (cmd_done),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: events are recorded as edge time-stamps, outputs derived arithmetically.
  int n = 0;
  int t_ch[N];
  int t_clr = NEVER;
  int t_o = NEVER;
  int t_o_old = NEVER;
  bit prev_ch[N];
  bit prev_o = 1'b0;
  int phase = 0;            // 0 no command, 1 offered, 2 in flight
  bit e_valid = 1'b0;
  bit e_busy = 1'b0;
  bit e_rd = 1'b0;
  int e_ch = 0;
  int ptr = 0;
  int age = 0;
  int done_lat = 2;
  int ready_mode = 1;       // 0 low, 1 high, 2 random
  bit spur_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit ch_in_rst(input int i, input int at);
    return (at - t_ch[i] >= 0) && (at - t_ch[i] < STR);
  endfunction

  function automatic bit o_in_rst(input int at);
    return ((at - t_o >= 0) && (at - t_o < STR)) || ((at - t_o_old >= 0) && (at - t_o_old < STR));
  endfunction

  function automatic bit hold_ok(input int at);
    return (at - t_clr >= HOLD) && !o_in_rst(at);
  endfunction

  function automatic int lvl(input int i);
    return int'(wr_level[i*LW +: LW]);
  endfunction

  task automatic set_lvl(input int c, input int v);
    wr_level[c*LW +: LW] = LW'(v);
  endtask

  task automatic model_edge();
    int  win;
    int  c;
    bit  rd_ok;
    bit  rd_pri;
    n++;
    if (rst) begin
      phase = 0; e_valid = 0; e_busy = 0; e_rd = 0; e_ch = 0; ptr = 0;
      t_clr = n; t_o = NEVER; t_o_old = NEVER; prev_o = 0;
      for (int i = 0; i < N; i++) begin t_ch[i] = NEVER; prev_ch[i] = 0; end
    end else begin
      case (phase)
        0: begin
          rd_ok = (int'(rd_level) < RD_TH) && hold_ok(n - 1);
`ifdef READ_PRIO_EN
          rd_pri = rd_ok && (int'(rd_level) < RD_CR);
`else
          rd_pri = 1'b0;
`endif
          win = -1;
          for (int k = 0; k < N; k++) begin
            c = (ptr + k) % N;
            if (win < 0 && lvl(c) >= WR_TH && !ch_in_rst(c, n - 1)) win = c;
          end
          if (rd_pri || (win < 0 && rd_ok)) begin
            e_valid = 1; e_rd = 1; e_ch = 0; phase = 1;
          end else if (win >= 0) begin
            e_valid = 1; e_rd = 0; e_ch = win; phase = 1;
          end
        end
        1: if (cmd_ready) begin
          e_valid = 0; e_busy = 1; phase = 2; age = 0;
          if (!e_rd) ptr = (e_ch + 1) % N;
        end
        default: if (cmd_done) begin
          e_busy = 0; phase = 0;
        end
      endcase
      for (int i = 0; i < N; i++) begin
        if (ch_rst_in[i] && !prev_ch[i]) t_ch[i] = n;
        prev_ch[i] = ch_rst_in[i];
      end
      if (o_rst_in && !prev_o) begin
        t_clr = n; t_o_old = t_o; t_o = n + 1;
      end
      prev_o = o_rst_in;
    end
  endtask

  task automatic tick();
    logic [N-1:0] exp_cr;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) exp_cr[i] = ch_in_rst(i, n);
    chk("cmd_valid", cmd_valid, e_valid);
    chk("busy", busy, e_busy);
    chk("o_fifo_rst", o_fifo_rst, o_in_rst(n));
    chk("ch_fifo_rst", ch_fifo_rst, exp_cr);
    if (e_valid) begin
      chk("cmd_is_rd", cmd_is_rd, e_rd);
      chk("cmd_ch", cmd_ch, e_ch);
    end
    case (ready_mode)
      0:       cmd_ready = 1'b0;
      1:       cmd_ready = 1'b1;
      default: cmd_ready = 1'($urandom_range(0, 1));
    endcase
    if (phase == 2) begin
      cmd_done = (age + 1 >= done_lat);
      age++;
    end else begin
      cmd_done = spur_done ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
  endtask

  task automatic settle();
    int c = 0;
    while ((cmd_valid || busy) && c < 100) begin tick(); c++; end
    chk("settle_bound", c < 100, 1);
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int got[5];
    int ng, c, hi, bad, first_hi;
    bit last_v, first_s;

    rst = 1; wr_level = '0; rd_level = '0; ch_rst_in = '0; o_rst_in = 0;
    cmd_ready = 0; cmd_done = 0;
    for (int i = 0; i < N; i++) begin t_ch[i] = NEVER; prev_ch[i] = 0; end
    repeat (3) tick();
    chk("reset_outputs", {cmd_valid, busy, cmd_is_rd, o_fifo_rst, ch_fifo_rst, cmd_ch}, 0);
    rst = 0;

    // Holdoff after reset: first read exactly HOLD+1 edges after release.
    c = 0;
    while (!cmd_valid && c < 1100) begin tick(); c++; end
    chk("holdoff_first_cmd_edge", c, HOLD + 1);
    chk("holdoff_is_rd", cmd_is_rd, 1);
    chk("holdoff_ch", cmd_ch, 0);

    // Round-robin with all channels at threshold.
    rd_level = 10'd300;
    for (int i = 0; i < N; i++) set_lvl(i, WR_TH);
    ng = 0; c = 0; last_v = cmd_valid;
    while (ng < 5 && c < 200) begin
      tick(); c++;
      if (cmd_valid && !last_v) begin got[ng] = int'(cmd_ch); ng++; end
      last_v = cmd_valid;
    end
    chk("rr_grant_count", ng, 5);
    for (int g = 0; g < 5; g++) chk("rr_order", got[g], exp_order[g]);
    wr_level = '0;
    settle();

    // Command held while ready is low and the level collapses.
    ready_mode = 0; cmd_ready = 0;
    set_lvl(2, 150);
    c = 0;
    while (!cmd_valid && c < 20) begin tick(); c++; end
    chk("hold_issue_bound", c < 20, 1);
    set_lvl(2, 0);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("hold_valid", cmd_valid, 1);
      chk("hold_ch", cmd_ch, 2);
    end
    ready_mode = 1; cmd_ready = 1;
    tick();
    chk("hold_busy_after_ready", busy, 1);
    chk("hold_valid_dropped", cmd_valid, 0);
    settle();

    // Channel reset stretch blocks grants to that channel.
    ch_rst_in[1] = 1'b1;
    tick();
    ch_rst_in[1] = 1'b0;
    set_lvl(1, 200);
    first_s = ch_fifo_rst[1];
    hi = 0; bad = 0;
    for (int j = 0; j < 30; j++) begin
      if (ch_fifo_rst[1]) begin
        hi++;
        if (cmd_valid && !cmd_is_rd && cmd_ch == 2'd1) bad++;
      end
      tick();
    end
    chk("ch_rst_first_cycle", first_s, 1);
    chk("ch_rst_len", hi, STR);
    chk("ch_rst_no_grant", bad, 0);
    set_lvl(1, 0);
    settle();

    // Output reset mid-burst, then read holdoff.
    set_lvl(0, 150);
    c = 0;
    while (!cmd_valid && c < 20) begin tick(); c++; end
    chk("orst_issue_bound", c < 20, 1);
    o_rst_in = 1;
    tick();
    o_rst_in = 0; set_lvl(0, 0); rd_level = '0;
    c = 0; hi = 0; first_hi = -1;
    while (!(cmd_valid && cmd_is_rd) && c < 1100) begin
      tick(); c++;
      if (o_fifo_rst) begin hi++; if (first_hi < 0) first_hi = c; end
    end
    chk("orst_first", first_hi, 1);
    chk("orst_len", hi, STR);
    chk("orst_read_edge", c, HOLD + 1);
    rd_level = 10'd300;
    settle();

    // Urgent read vs eligible write.
    set_lvl(0, 130); rd_level = 10'd10;
    c = 0;
    while (!cmd_valid && c < 20) begin tick(); c++; end
`ifdef READ_PRIO_EN
    chk("prio_is_rd", cmd_is_rd, 1);
    chk("prio_ch", cmd_ch, 0);
`else
    chk("prio_is_rd", cmd_is_rd, 0);
    chk("prio_ch", cmd_ch, 0);
`endif
    rd_level = 10'd300; set_lvl(0, 0);
    settle();

    // Randomized traffic.
    ready_mode = 2; spur_done = 1;
    for (int j = 0; j < 3000; j++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) set_lvl(i, int'($urandom_range(100, 140)));
      if ($urandom_range(0, 15) == 0) rd_level = LW'($urandom_range(0, 300));
      for (int i = 0; i < N; i++) ch_rst_in[i] = ($urandom_range(0, 63) == 0);
      o_rst_in = ($urandom_range(0, 499) == 0);
      done_lat = int'($urandom_range(1, 4));
      tick();
    end

    // Reset overrides activity in flight.
    for (int i = 0; i < N; i++) set_lvl(i, WR_TH);
    c = 0;
    while (!(cmd_valid || busy) && c < 50) begin tick(); c++; end
    rst = 1;
    tick();
    chk("rst_override", {cmd_valid, busy, cmd_is_rd, o_fifo_rst, ch_fifo_rst, cmd_ch}, 0);
    rst = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
